// File: rtl/stage_muldiv_pkg.sv
`default_nettype none
// ==== stage_muldiv_pkg : op/state encodings and divide helpers for the execute-stage muldiv unit ====
// ==== Rev 1.0 ====
package stage_muldiv_pkg;

  localparam int MD_OP_LEN = 3;
  localparam int CNT_W     = 4;

  typedef enum logic [MD_OP_LEN-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_MADD  = 3'd7
  } md_op_e;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_pair_t;

  // Signed divide; the -2^31 / -1 overflow case is resolved explicitly to
  // quotient 0x80000000, remainder 0. A zero divisor yields zeros (caller discards).
  function automatic md_pair_t md_sdiv(input logic [31:0] a, input logic [31:0] b);
    md_pair_t r;
    r.hi = '0;
    r.lo = '0;
    if (b == 32'hFFFF_FFFF) begin
      r.lo = 32'd0 - a;
    end else if (b != 32'd0) begin
      r.lo = $signed(a) / $signed(b);
      r.hi = $signed(a) % $signed(b);
    end
    return r;
  endfunction

  function automatic md_pair_t md_udiv(input logic [31:0] a, input logic [31:0] b);
    md_pair_t r;
    r.hi = '0;
    r.lo = '0;
    if (b != 32'd0) begin
      r.lo = a / b;
      r.hi = a % b;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stage_muldiv_if.sv
`default_nettype none
// ==== stage_muldiv_if : decode/execute handshake and HI/LO read-back for the muldiv unit ====
// ==== Rev 1.0 ====
interface stage_muldiv_if;
  import stage_muldiv_pkg::*;

  logic        start;
  md_op_e      op;
  logic [31:0] src0;
  logic [31:0] src1;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, src0, src1,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, src0, src1,
    output busy, hi, lo
  );

endinterface
`default_nettype wire

// File: rtl/stage_muldiv.sv
`default_nettype none
// ==== stage_muldiv : fixed-latency MULT/MULTU/DIV/DIVU plus MTHI/MTLO; owns HI/LO ====
// ==== MULDIV_MADD_EN enables MADD (signed {hi,lo} += src0*src1). Rev 1.0 ====
module stage_muldiv
  import stage_muldiv_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  wire logic     clk,
  input  wire logic     reset,
  stage_muldiv_if.slave md
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  md_pair_t         pend_q;
  logic             pend_wr_q;

  logic [63:0]      prod_s;
  logic [63:0]      prod_u;
  md_pair_t         sdiv_res;
  md_pair_t         udiv_res;

  logic             launch;
  logic             mthi;
  logic             mtlo;
  md_pair_t         pend_d;
  logic             pend_wr_d;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    prod_s   = {{32{md.src0[31]}}, md.src0} * {{32{md.src1[31]}}, md.src1};
    prod_u   = {32'd0, md.src0} * {32'd0, md.src1};
    sdiv_res = md_sdiv(md.src0, md.src1);
    udiv_res = md_udiv(md.src0, md.src1);
  end

  // Decode of an accepted start; a start seen while RUN never reaches here.
  always_comb begin
    launch    = 1'b0;
    mthi      = 1'b0;
    mtlo      = 1'b0;
    pend_d    = '0;
    pend_wr_d = 1'b0;
    cnt_d     = MUL_CNT;
    if (state_q == S_IDLE && md.start) begin
      case (md.op)
        MD_MULT: begin
          launch    = 1'b1;
          pend_wr_d = 1'b1;
          pend_d    = prod_s;
        end
        MD_MULTU: begin
          launch    = 1'b1;
          pend_wr_d = 1'b1;
          pend_d    = prod_u;
        end
        MD_DIV: begin
          launch    = 1'b1;
          cnt_d     = DIV_CNT;
          pend_wr_d = (md.src1 != 32'd0);
          pend_d    = sdiv_res;
        end
        MD_DIVU: begin
          launch    = 1'b1;
          cnt_d     = DIV_CNT;
          pend_wr_d = (md.src1 != 32'd0);
          pend_d    = udiv_res;
        end
        MD_MTHI: mthi = 1'b1;
        MD_MTLO: mtlo = 1'b1;
`ifdef MULDIV_MADD_EN
        MD_MADD: begin
          launch    = 1'b1;
          pend_wr_d = 1'b1;
          pend_d    = {hi_q, lo_q} + prod_s;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (launch) begin
            state_q   <= S_RUN;
            busy_q    <= 1'b1;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
          end
          if (mthi) hi_q <= md.src0;
          if (mtlo) lo_q <= md.src0;
        end
        S_RUN: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            pend_wr_q <= 1'b0;
            if (pend_wr_q) begin
              hi_q <= pend_q.hi;
              lo_q <= pend_q.lo;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign md.busy = busy_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_muldiv.sv
`default_nettype none
// ==== tb_stage_muldiv : directed + random checks of stage_muldiv against an arithmetic model ====
// ==== Rev 1.0 ====
module tb_stage_muldiv;
  import stage_muldiv_pkg::*;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  stage_muldiv_if u_if ();

  stage_muldiv #(
    .MUL_CYCLES(MUL_N),
    .DIV_CYCLES(DIV_N)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .md   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one accepted op: busy length and new HI/LO.
  function automatic void model(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] hi, input logic [31:0] lo,
                                output int n, output logic [31:0] nhi, output logic [31:0] nlo);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    n   = 0;
    nhi = hi;
    nlo = lo;
    case (op)
      MD_MULT:  begin n = MUL_N; p = sa * sb; {nhi, nlo} = p; end
      MD_MULTU: begin n = MUL_N; p = {32'd0, a} * {32'd0, b}; {nhi, nlo} = p; end
      MD_DIV: begin
        n = DIV_N;
        if (b != 32'd0) begin
          q = sa / sb; r = sa % sb;
          nlo = q[31:0]; nhi = r[31:0];
        end
      end
      MD_DIVU: begin
        n = DIV_N;
        if (b != 32'd0) begin nlo = a / b; nhi = a % b; end
      end
      MD_MTHI: nhi = a;
      MD_MTLO: nlo = a;
      MD_MADD: begin
`ifdef MULDIV_MADD_EN
        n = MUL_N;
        p = {hi, lo} + 64'(sa * sb);
        {nhi, nlo} = p;
`endif
      end
      default: ;
    endcase
  endfunction

  // Issue one op; optionally pulse a second start on busy cycle intr_k.
  task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input int intr_k, input md_op_e iop, input logic [31:0] ia, input logic [31:0] ib);
    int          n;
    logic [31:0] nhi, nlo;
    model(op, a, b, m_hi, m_lo, n, nhi, nlo);
    u_if.start = 1'b1; u_if.op = op; u_if.src0 = a; u_if.src1 = b;
    @(posedge clk); #1;
    u_if.start = 1'b0; u_if.op = MD_NONE;
    for (int k = 1; k <= n; k++) begin
      check("busy_run", {31'd0, u_if.busy}, 32'd1);
      check("hi_hold", u_if.hi, m_hi);
      check("lo_hold", u_if.lo, m_lo);
      if (k == intr_k) begin
        u_if.start = 1'b1; u_if.op = iop; u_if.src0 = ia; u_if.src1 = ib;
      end
      @(posedge clk); #1;
      u_if.start = 1'b0; u_if.op = MD_NONE;
    end
    m_hi = nhi;
    m_lo = nlo;
    check("busy_done", {31'd0, u_if.busy}, 32'd0);
    check("hi_result", u_if.hi, m_hi);
    check("lo_result", u_if.lo, m_lo);
  endtask

  initial begin
    md_op_e      rop, iop;
    logic [31:0] ra, rb;
    int          ik;
    n_assert = 0; n_fail = 0;
    m_hi = '0; m_lo = '0;
    reset = 1'b0;
    u_if.start = 1'b0; u_if.op = MD_NONE; u_if.src0 = '0; u_if.src1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, u_if.busy}, 32'd0);
    check("reset_hi", u_if.hi, 32'd0);
    check("reset_lo", u_if.lo, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, 0, MD_NONE, 0, 0);
    run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 0, MD_NONE, 0, 0);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 0, MD_NONE, 0, 0);
    run_op(MD_DIVU,  32'd7,         32'd2, 0, MD_NONE, 0, 0);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, MD_NONE, 0, 0);
    run_op(MD_MTHI,  32'h1234, 32'd0, 0, MD_NONE, 0, 0);
    run_op(MD_MTLO,  32'h5678, 32'd0, 0, MD_NONE, 0, 0);
    run_op(MD_DIV,   32'h0BAD_F00D, 32'd0, 0, MD_NONE, 0, 0);
    run_op(MD_DIVU,  32'd100, 32'd7, 2, MD_MULT, 32'd3, 32'd3);
    run_op(MD_MTHI,  32'd0, 32'd0, 0, MD_NONE, 0, 0);
    run_op(MD_MTLO,  32'hFFFF_FFFF, 32'd0, 0, MD_NONE, 0, 0);
    run_op(MD_MADD,  32'd1, 32'd1, 0, MD_NONE, 0, 0);

    for (int i = 0; i < 40; i++) begin
      rop = md_op_e'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      ik  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, MUL_N) : 0;
      iop = md_op_e'($urandom_range(1, 7));
      run_op(rop, ra, rb, ik, iop, $urandom, $urandom);
    end

    run_op(MD_MTHI, 32'hDEAD_BEEF, 32'd0, 0, MD_NONE, 0, 0);
    u_if.start = 1'b1; u_if.op = MD_MULT; u_if.src0 = 32'd5; u_if.src1 = 32'd5;
    @(posedge clk); #1;
    u_if.start = 1'b0; u_if.op = MD_NONE;
    for (int k = 1; k <= 2; k++) begin
      check("pre_rst_busy", {31'd0, u_if.busy}, 32'd1);
      @(posedge clk); #1;
    end
    #2 reset = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    check("rst_mid_busy", {31'd0, u_if.busy}, 32'd0);
    check("rst_mid_hi", u_if.hi, m_hi);
    check("rst_mid_lo", u_if.lo, m_lo);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("post_rst_busy", {31'd0, u_if.busy}, 32'd0);
      check("post_rst_hi", u_if.hi, m_hi);
      check("post_rst_lo", u_if.lo, m_lo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
